// File: rtl/lsu_bus_initiator.sv
// lsu_bus_initiator: turns single CPU load/store requests into one-shot bus
// requests on a word-wide data bus, with lane masking, store-data
// replication and load-result extraction/extension.
// Optional build macro LSU_TIMEOUT_EN bounds the WAIT state to
// TIMEOUT_CYCLES cycles and reports a timeout as cpu_err.
module lsu_bus_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_signed,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ready,
  output logic        cpu_done,
  output logic        cpu_err,
  output logic [31:0] cpu_rdata,
  output logic        data_req,
  output logic        data_wren,
  output logic [3:0]  data_mask,
  output logic [31:0] data_addr,
  output logic [31:0] data_data,
  input  logic        data_ack,
  input  logic [31:0] data_q
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_we;
  logic        r_signed;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_err;
  logic [31:0] r_rdata;

  logic        w_accept;
  logic        w_misaligned;
  logic        w_ack_done;
  logic        w_timeout;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;

  assign w_accept     = (r_state == ST_IDLE) && cpu_req;
  assign w_misaligned = (cpu_size == 2'd3)
                     || ((cpu_size == 2'd1) && cpu_addr[0])
                     || ((cpu_size == 2'd2) && (cpu_addr[1:0] != 2'b00));
  assign w_ack_done   = (r_state == ST_WAIT) && data_ack;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_tcnt;

  // WAIT-cycle counter, starting at 0 on the first WAIT cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                r_tcnt <= '0;
    else if (r_state == ST_WAIT) r_tcnt <= r_tcnt + 1'b1;
    else                         r_tcnt <= '0;
  end

  // an ack on the final count cycle takes priority over the timeout
  assign w_timeout = (r_state == ST_WAIT) && !data_ack
                  && (r_tcnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // next-state and bus/CPU handshake outputs
  always_comb begin
    w_next    = r_state;
    cpu_ready = 1'b0;
    cpu_done  = 1'b0;
    data_req  = 1'b0;
    data_wren = 1'b0;
    data_mask = '0;
    data_addr = '0;
    data_data = '0;
    case (r_state)
      ST_IDLE: begin
        cpu_ready = 1'b1;
        if (cpu_req) w_next = w_misaligned ? ST_DONE : ST_ISSUE;
      end
      ST_ISSUE: begin
        data_req  = 1'b1;
        data_wren = r_we;
        data_addr = {r_addr[31:2], 2'b00};
        case (r_size)
          2'd0:    data_mask = 4'b0001 << r_addr[1:0];
          2'd1:    data_mask = 4'b0011 << r_addr[1:0];
          default: data_mask = 4'b1111;
        endcase
        case (r_size)
          2'd0:    data_data = {4{r_wdata[7:0]}};
          2'd1:    data_data = {2{r_wdata[15:0]}};
          default: data_data = r_wdata;
        endcase
        w_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (data_ack || w_timeout) w_next = ST_DONE;
      end
      default: begin
        cpu_done = 1'b1;
        w_next   = ST_IDLE;
      end
    endcase
  end

  // load result: pick the addressed lane and extend it
  always_comb begin
    w_byte = data_q[{r_addr[1:0], 3'b000} +: 8];
    w_half = r_addr[1] ? data_q[31:16] : data_q[15:0];
    case (r_size)
      2'd0:    w_load = {{24{r_signed & w_byte[7]}}, w_byte};
      2'd1:    w_load = {{16{r_signed & w_half[15]}}, w_half};
      default: w_load = data_q;
    endcase
  end

  // request attributes captured on acceptance
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_we     <= 1'b0;
      r_signed <= 1'b0;
      r_size   <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else if (w_accept) begin
      r_we     <= cpu_we;
      r_signed <= cpu_signed;
      r_size   <= cpu_size;
      r_addr   <= cpu_addr;
      r_wdata  <= cpu_wdata;
    end
  end

  // completion status, loaded on entry to DONE and held until the next one
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else if (w_accept && w_misaligned) begin
      r_err   <= 1'b1;
      r_rdata <= '0;
    end else if (w_ack_done) begin
      r_err   <= 1'b0;
      r_rdata <= r_we ? '0 : w_load;
    end else if (w_timeout) begin
      r_err   <= 1'b1;
      r_rdata <= '0;
    end
  end

  assign cpu_err   = r_err;
  assign cpu_rdata = r_rdata;

endmodule
